// File: rtl/pc_pkg.sv
// Shared constants for the PC next-address unit: op classes, condition codes, flag bit positions.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package pc_pkg;

  // Op class field, op[7:4]
  localparam logic [3:0] CLS_BRANCH = 4'b1100;
  localparam logic [3:0] CLS_JUMP   = 4'b1000;
  localparam logic [3:0] CLS_JAL    = 4'b1001;
  localparam logic [3:0] CLS_RET    = 4'b1010;

  // Condition field, op[3:0]
  localparam logic [3:0] CC_EQ = 4'b0000;
  localparam logic [3:0] CC_NE = 4'b0001;
  localparam logic [3:0] CC_CS = 4'b0010;
  localparam logic [3:0] CC_CC = 4'b0011;
  localparam logic [3:0] CC_HI = 4'b0100;
  localparam logic [3:0] CC_LS = 4'b0101;
  localparam logic [3:0] CC_GT = 4'b0110;
  localparam logic [3:0] CC_LE = 4'b0111;
  localparam logic [3:0] CC_FS = 4'b1000;
  localparam logic [3:0] CC_FC = 4'b1001;
  localparam logic [3:0] CC_LO = 4'b1010;
  localparam logic [3:0] CC_HS = 4'b1011;
  localparam logic [3:0] CC_LT = 4'b1100;
  localparam logic [3:0] CC_GE = 4'b1101;
  localparam logic [3:0] CC_UC = 4'b1110;
  localparam logic [3:0] CC_NV = 4'b1111;

  // Bit positions inside the flag vector
  localparam int FLG_C = 0;
  localparam int FLG_L = 1;
  localparam int FLG_F = 2;
  localparam int FLG_Z = 3;
  localparam int FLG_N = 4;

  // True for the four classes that can redirect the PC
  function automatic logic is_ctrl_class(input logic [3:0] cls);
    return (cls == CLS_BRANCH) || (cls == CLS_JUMP) ||
           (cls == CLS_JAL)    || (cls == CLS_RET);
  endfunction

endpackage

// File: rtl/pc_next_unit_cond_eval.sv
// Condition-code evaluator: 4-bit condition against the 5-bit flag vector -> pass.
// Latency: purely combinational, zero cycles.
// Backpressure: none; no state.
module cond_eval
  import pc_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [4:0] i_flags,
  output logic       o_pass
);

  logic w_c;
  logic w_l;
  logic w_f;
  logic w_z;
  logic w_n;

  assign w_c = i_flags[FLG_C];
  assign w_l = i_flags[FLG_L];
  assign w_f = i_flags[FLG_F];
  assign w_z = i_flags[FLG_Z];
  assign w_n = i_flags[FLG_N];

  // Decode each condition code into its flag predicate
  always_comb begin
    o_pass = 1'b0;
    case (i_cond)
      CC_EQ: o_pass = w_z;
      CC_NE: o_pass = ~w_z;
      CC_CS: o_pass = w_c;
      CC_CC: o_pass = ~w_c;
      CC_HI: o_pass = w_l;
      CC_LS: o_pass = ~w_l;
      CC_GT: o_pass = w_n;
      CC_LE: o_pass = ~w_n;
      CC_FS: o_pass = w_f;
      CC_FC: o_pass = ~w_f;
      CC_LO: o_pass = ~w_l & ~w_z;
      CC_HS: o_pass = w_l | w_z;
      CC_LT: o_pass = ~w_n & ~w_z;
      CC_GE: o_pass = w_n | w_z;
      CC_UC: o_pass = 1'b1;
      CC_NV: o_pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_next_unit.sv
// PC register with branch/jump/JAL/RET next-address selection and a circular return-address stack.
// Latency: taken is combinational; pc, flush and link outputs update one cycle after the op.
// Backpressure: i_en=0 stalls all state; flush/link_we drop to 0 while stalled.
module pc_next_unit #(
  parameter int                PC_W      = 16,
  parameter int                DISP_W    = 9,
  parameter int                RAS_DEPTH = 4,
  parameter logic [PC_W-1:0]   RESET_VEC = '0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_en,
  input  logic              i_instr_valid,
  input  logic [7:0]        i_op,
  input  logic [4:0]        i_flags,
  input  logic [DISP_W-1:0] i_disp,
  input  logic [PC_W-1:0]   i_target,
  output logic [PC_W-1:0]   o_pc,
  output logic              o_taken,
  output logic              o_flush,
  output logic              o_link_we,
  output logic [PC_W-1:0]   o_link_out,
  output logic              o_ras_empty,
  output logic              o_ras_full,
  output logic              o_ras_err
);

  import pc_pkg::*;

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [PC_W-1:0]  r_pc;
  logic             r_flush;
  logic             r_link_we;
  logic [PC_W-1:0]  r_link_out;
  logic             r_ras_err;
  logic [PC_W-1:0]  r_ras [RAS_DEPTH];
  logic [PTR_W-1:0] r_top;
  logic [CNT_W-1:0] r_cnt;

  logic [3:0]       w_cls;
  logic             w_pass;
  logic             w_is_ctrl;
  logic             w_is_jal;
  logic             w_is_ret;
  logic             w_ras_empty;
  logic             w_ras_full;
  logic             w_taken;
  logic [PC_W-1:0]  w_pc_inc;
  logic [PC_W-1:0]  w_disp_ext;
  logic [PC_W-1:0]  w_tgt;
  logic [PTR_W-1:0] w_top_inc;
  logic             w_push;
  logic             w_pop;
  logic             w_underflow;

  cond_eval u_cond_eval (
    .i_cond  (i_op[3:0]),
    .i_flags (i_flags),
    .o_pass  (w_pass)
  );

  assign w_cls       = i_op[7:4];
  assign w_is_ctrl   = is_ctrl_class(w_cls);
  assign w_is_jal    = (w_cls == CLS_JAL);
  assign w_is_ret    = (w_cls == CLS_RET);
  assign w_ras_empty = (r_cnt == '0);
  assign w_ras_full  = (r_cnt == CNT_W'(RAS_DEPTH));

  // A RET with nothing to return to is refused rather than jumping to stale data
  assign w_taken = i_instr_valid & w_is_ctrl & w_pass & ~(w_is_ret & w_ras_empty);

  // All PC arithmetic wraps modulo 2^PC_W
  assign w_pc_inc   = r_pc + PC_W'(1);
  assign w_disp_ext = {{(PC_W-DISP_W){i_disp[DISP_W-1]}}, i_disp};
  assign w_top_inc  = r_top + PTR_W'(1);

  assign w_push      = i_en & w_taken & w_is_jal;
  assign w_pop       = i_en & w_taken & w_is_ret;
  assign w_underflow = i_en & i_instr_valid & w_is_ret & w_pass & w_ras_empty;

  // Redirect target for the current control op
  always_comb begin
    w_tgt = w_pc_inc;
    case (w_cls)
      CLS_BRANCH: w_tgt = r_pc + w_disp_ext;
      CLS_JUMP:   w_tgt = i_target;
      CLS_JAL:    w_tgt = i_target;
      CLS_RET:    w_tgt = r_ras[r_top];
      default:    w_tgt = w_pc_inc;
    endcase
  end

  // PC, flush pulse and link-register outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc       <= RESET_VEC;
      r_flush    <= 1'b0;
      r_link_we  <= 1'b0;
      r_link_out <= '0;
    end else if (i_en) begin
      r_pc      <= w_taken ? w_tgt : w_pc_inc;
      r_flush   <= w_taken;
      r_link_we <= w_push;
      if (w_push) begin
        r_link_out <= w_pc_inc;
      end
    end else begin
      r_flush   <= 1'b0;
      r_link_we <= 1'b0;
    end
  end

  // Stack storage: a push lands one slot above the current top, overwriting the oldest when full
  always_ff @(posedge i_clk) begin
    if (!i_reset && w_push) begin
      r_ras[w_top_inc] <= w_pc_inc;
    end
  end

  // Top pointer and saturating occupancy count
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_top <= '0;
      r_cnt <= '0;
    end else if (w_push) begin
      r_top <= w_top_inc;
      if (!w_ras_full) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end else if (w_pop) begin
      r_top <= r_top - PTR_W'(1);
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Sticky underflow indicator, cleared only by reset
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ras_err <= 1'b0;
    end else if (w_underflow) begin
      r_ras_err <= 1'b1;
    end
  end

  assign o_pc        = r_pc;
  assign o_taken     = w_taken;
  assign o_flush     = r_flush;
  assign o_link_we   = r_link_we;
  assign o_link_out  = r_link_out;
  assign o_ras_empty = w_ras_empty;
  assign o_ras_full  = w_ras_full;
  assign o_ras_err   = r_ras_err;

endmodule

// File: tb/tb_pc_next_unit.sv
// Testbench for pc_next_unit: condition table sweep, directed redirect/stack sequences, random vs model.
// Latency: checks registered outputs 1 time unit after each rising edge, taken before the edge.
// Backpressure: exercises i_en stalls directly and randomly.
module tb_pc_next_unit;

  import pc_pkg::*;

  localparam int          PC_W      = 16;
  localparam int          DISP_W    = 9;
  localparam int          RAS_DEPTH = 4;
  localparam logic [15:0] RV        = 16'h0010;

  logic              i_clk;
  logic              i_reset;
  logic              i_en;
  logic              i_instr_valid;
  logic [7:0]        i_op;
  logic [4:0]        i_flags;
  logic [DISP_W-1:0] i_disp;
  logic [PC_W-1:0]   i_target;
  logic [PC_W-1:0]   o_pc;
  logic              o_taken;
  logic              o_flush;
  logic              o_link_we;
  logic [PC_W-1:0]   o_link_out;
  logic              o_ras_empty;
  logic              o_ras_full;
  logic              o_ras_err;

  int n_checks;
  int n_errors;

  pc_next_unit #(
    .PC_W      (PC_W),
    .DISP_W    (DISP_W),
    .RAS_DEPTH (RAS_DEPTH),
    .RESET_VEC (RV)
  ) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_en          (i_en),
    .i_instr_valid (i_instr_valid),
    .i_op          (i_op),
    .i_flags       (i_flags),
    .i_disp        (i_disp),
    .i_target      (i_target),
    .o_pc          (o_pc),
    .o_taken       (o_taken),
    .o_flush       (o_flush),
    .o_link_we     (o_link_we),
    .o_link_out    (o_link_out),
    .o_ras_empty   (o_ras_empty),
    .o_ras_full    (o_ras_full),
    .o_ras_err     (o_ras_err)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  typedef struct {
    logic [3:0] cond;
    logic [4:0] flags;
    logic       exp_taken;
  } vec_t;

  vec_t vt[48];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_en          = 1'b1;
    i_instr_valid = 1'b0;
    i_op          = 8'h00;
    i_flags       = 5'b00000;
    i_disp        = '0;
    i_target      = '0;
  endtask

  task automatic do_reset();
    idle();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
  endtask

  task automatic issue(input logic [3:0] cls, input logic [3:0] cond,
                       input logic [15:0] tgt, input logic [8:0] disp);
    i_instr_valid = 1'b1;
    i_op          = {cls, cond};
    i_target      = tgt;
    i_disp        = disp;
  endtask

  task automatic jump_to(input logic [15:0] addr);
    issue(CLS_JUMP, CC_UC, addr, 9'h000);
    tick();
    idle();
  endtask

  // Reference condition rules, straight from the condition table
  function automatic logic ref_pass(input logic [3:0] cond, input logic [4:0] f);
    logic c, l, ff, z, n;
    c = f[0]; l = f[1]; ff = f[2]; z = f[3]; n = f[4];
    case (cond)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return l;
      4'd5:  return !l;
      4'd6:  return n;
      4'd7:  return !n;
      4'd8:  return ff;
      4'd9:  return !ff;
      4'd10: return !l && !z;
      4'd11: return l || z;
      4'd12: return !n && !z;
      4'd13: return n || z;
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Model state for the random phase
  logic [15:0] m_pc;
  logic [15:0] m_q[$];
  logic        m_err;
  logic        m_flush;
  logic        m_lwe;
  logic [15:0] m_lout;

  initial begin
    logic [2:0]  masks[16];
    logic [4:0]  fl[3];
    logic [15:0] rets[4];
    n_checks = 0;
    n_errors = 0;
    i_reset  = 1'b0;
    idle();

    // Expected taken for each condition across flag patterns, bit k = pattern k
    masks = '{3'b110, 3'b001, 3'b000, 3'b111, 3'b100, 3'b011, 3'b100, 3'b011,
              3'b000, 3'b111, 3'b001, 3'b110, 3'b001, 3'b110, 3'b111, 3'b000};
    fl    = '{5'b00000, 5'b01000, 5'b11010};
    for (int c = 0; c < 16; c++) begin
      for (int k = 0; k < 3; k++) begin
        vt[c*3+k].cond      = 4'(c);
        vt[c*3+k].flags     = fl[k];
        vt[c*3+k].exp_taken = masks[c][k];
      end
    end

    // Reset and free-running increment
    do_reset();
    chk("rst_pc", o_pc, 16'h0010);
    chk("rst_flush", o_flush, 0);
    chk("rst_link_we", o_link_we, 0);
    chk("rst_link_out", o_link_out, 0);
    chk("rst_empty", o_ras_empty, 1);
    chk("rst_full", o_ras_full, 0);
    chk("rst_err", o_ras_err, 0);
    tick();
    chk("inc_pc1", o_pc, 16'h0011);
    chk("inc_flush1", o_flush, 0);
    tick();
    chk("inc_pc2", o_pc, 16'h0012);
    chk("inc_flush2", o_flush, 0);

    // Condition sweep, stalled so state does not move
    i_en = 1'b0;
    for (int v = 0; v < 48; v++) begin
      issue(CLS_BRANCH, vt[v].cond, 16'h0000, 9'h001);
      i_flags = vt[v].flags;
      #1;
      chk($sformatf("cond_sweep_%0d_%b", vt[v].cond, vt[v].flags), o_taken, vt[v].exp_taken);
    end
    i_op = {4'b0000, CC_UC};
    #1;
    chk("noncontrol_class", o_taken, 0);
    i_op = {CLS_JUMP, CC_UC};
    i_instr_valid = 1'b0;
    #1;
    chk("invalid_op", o_taken, 0);
    tick();
    chk("sweep_pc_held", o_pc, 16'h0012);
    idle();

    // Relative branch backwards, then not-taken variant
    jump_to(16'h0020);
    issue(CLS_BRANCH, CC_EQ, 16'h0000, 9'h1FC);
    i_flags = 5'b01000;
    #1;
    chk("br_taken", o_taken, 1);
    tick();
    idle();
    chk("br_pc", o_pc, 16'h001C);
    chk("br_flush", o_flush, 1);
    tick();
    chk("br_flush_once", o_flush, 0);
    jump_to(16'h0020);
    issue(CLS_BRANCH, CC_EQ, 16'h0000, 9'h1FC);
    i_flags = 5'b00000;
    #1;
    chk("br_nt_taken", o_taken, 0);
    tick();
    idle();
    chk("br_nt_pc", o_pc, 16'h0021);
    chk("br_nt_flush", o_flush, 0);

    // JAL then RET
    jump_to(16'h0100);
    issue(CLS_JAL, CC_UC, 16'h0400, 9'h000);
    tick();
    idle();
    chk("jal_pc", o_pc, 16'h0400);
    chk("jal_link_we", o_link_we, 1);
    chk("jal_link_out", o_link_out, 16'h0101);
    chk("jal_empty", o_ras_empty, 0);
    issue(CLS_RET, CC_UC, 16'h0000, 9'h000);
    tick();
    idle();
    chk("ret_pc", o_pc, 16'h0101);
    chk("ret_empty", o_ras_empty, 1);
    chk("ret_link_we", o_link_we, 0);

    // Stack overflow wraps, then underflow sets the sticky error
    do_reset();
    for (int j = 1; j <= 5; j++) begin
      jump_to(16'(j * 16));
      issue(CLS_JAL, CC_UC, 16'h0200, 9'h000);
      tick();
      idle();
    end
    chk("ovf_full", o_ras_full, 1);
    rets = '{16'h0051, 16'h0041, 16'h0031, 16'h0021};
    for (int j = 0; j < 4; j++) begin
      issue(CLS_RET, CC_UC, 16'h0000, 9'h000);
      tick();
      chk($sformatf("ovf_ret%0d_pc", j), o_pc, rets[j]);
    end
    chk("ovf_empty", o_ras_empty, 1);
    chk("ovf_err_before", o_ras_err, 0);
    #1;
    chk("unf_taken", o_taken, 0);
    tick();
    idle();
    chk("unf_pc", o_pc, 16'h0022);
    chk("unf_flush", o_flush, 0);
    chk("unf_err", o_ras_err, 1);
    tick();
    chk("unf_err_sticky", o_ras_err, 1);

    // PC wrap, then a stalled branch followed by one redirect
    jump_to(16'hFFFF);
    tick();
    chk("wrap_pc", o_pc, 16'h0000);
    issue(CLS_BRANCH, CC_UC, 16'h0000, 9'h005);
    i_en = 1'b0;
    for (int j = 0; j < 2; j++) begin
      #1;
      chk("stall_taken", o_taken, 1);
      tick();
      chk("stall_pc", o_pc, 16'h0000);
      chk("stall_flush", o_flush, 0);
    end
    i_en = 1'b1;
    tick();
    idle();
    chk("unstall_pc", o_pc, 16'h0005);
    chk("unstall_flush", o_flush, 1);
    tick();
    chk("unstall_flush_once", o_flush, 0);
    chk("unstall_pc_inc", o_pc, 16'h0006);

    // Reset coinciding with a redirect drops the flush
    issue(CLS_JUMP, CC_UC, 16'h0777, 9'h000);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    idle();
    chk("rst_redirect_pc", o_pc, RV);
    chk("rst_redirect_flush", o_flush, 0);
    chk("rst_redirect_err", o_ras_err, 0);

    // Random phase against the behavioural model
    do_reset();
    m_pc = RV; m_q.delete(); m_err = 0; m_flush = 0; m_lwe = 0; m_lout = 0;
    for (int i = 0; i < 1500; i++) begin
      logic [3:0]  cls;
      logic [3:0]  cond;
      int          r;
      logic        pass;
      logic        is_ctrl;
      logic        exp_taken;
      logic [15:0] tgt;
      logic [15:0] inc;
      r    = $urandom_range(0, 9);
      cls  = (r < 3) ? CLS_JAL : (r < 6) ? CLS_RET : (r == 6) ? CLS_BRANCH :
             (r == 7) ? CLS_JUMP : 4'($urandom_range(0, 15));
      cond = ($urandom_range(0, 1) == 0) ? CC_UC : 4'($urandom_range(0, 15));
      i_reset       = ($urandom_range(0, 99) == 0);
      i_en          = ($urandom_range(0, 3) != 0);
      i_instr_valid = ($urandom_range(0, 4) != 0);
      i_op          = {cls, cond};
      i_flags       = 5'($urandom_range(0, 31));
      i_disp        = 9'($urandom_range(0, 511));
      i_target      = 16'($urandom_range(0, 65535));
      #1;
      pass      = ref_pass(cond, i_flags);
      is_ctrl   = (cls == CLS_BRANCH) || (cls == CLS_JUMP) || (cls == CLS_JAL) || (cls == CLS_RET);
      exp_taken = i_instr_valid && is_ctrl && pass && !(cls == CLS_RET && m_q.size() == 0);
      chk("rand_taken", o_taken, exp_taken);
      inc = m_pc + 16'd1;
      if (i_reset) begin
        m_pc = RV; m_q.delete(); m_err = 0; m_flush = 0; m_lwe = 0; m_lout = 0;
      end else if (i_en) begin
        if (cls == CLS_BRANCH) tgt = m_pc + 16'(signed'(i_disp));
        else if (cls == CLS_RET && m_q.size() != 0) tgt = m_q[$];
        else tgt = i_target;
        m_flush = exp_taken;
        m_lwe   = exp_taken && cls == CLS_JAL;
        if (exp_taken && cls == CLS_JAL) begin
          m_lout = inc;
          if (m_q.size() == RAS_DEPTH) m_q.delete(0);
          m_q.push_back(inc);
        end
        if (exp_taken && cls == CLS_RET) void'(m_q.pop_back());
        if (i_instr_valid && cls == CLS_RET && pass && !exp_taken) m_err = 1;
        m_pc = exp_taken ? tgt : inc;
      end else begin
        m_flush = 0;
        m_lwe   = 0;
      end
      tick();
      chk("rand_pc", o_pc, m_pc);
      chk("rand_flush", o_flush, m_flush);
      chk("rand_link_we", o_link_we, m_lwe);
      chk("rand_link_out", o_link_out, m_lout);
      chk("rand_empty", o_ras_empty, m_q.size() == 0);
      chk("rand_full", o_ras_full, m_q.size() == RAS_DEPTH);
      chk("rand_err", o_ras_err, m_err);
    end
    i_reset = 1'b0;
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
